// File: rtl/temporal_pkg.sv
// rtl/temporal_pkg.sv - shared FSM state encoding and infinity helper for the temporal encoder
package temporal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2,
        ST_DONE  = 2'd3
    } temporal_state_e;

    // A spike time at or beyond the window length means "no spike in this window".
    function automatic logic is_infinite(input int unsigned value, input int unsigned gamma_len);
        return value >= gamma_len;
    endfunction

endpackage

// File: rtl/temporal_encoder_if.sv
// rtl/temporal_encoder_if.sv - spike-time input handshake bundle for the temporal encoder
interface temporal_encoder_if #(
    parameter int VAL_WIDTH = 5
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [VAL_WIDTH-1:0] in_value;

    modport master (output in_valid, output in_value, input in_ready);
    modport slave  (input in_valid, input in_value, output in_ready);

endinterface

// File: rtl/gamma_counter.sv
// rtl/gamma_counter.sv - gamma window time counter, loads on gamma_start and saturates at G-1
module gamma_counter #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    localparam int TW = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          load,
    input  logic          run,
    output logic [TW-1:0] t_next,
    output logic          win_end
);

    localparam logic [TW-1:0] T_MAX = TW'(GAMMA_CYCLE_WIDTH - 1);

    logic [TW-1:0] t;

    // The last cycle of a window is the one where t already sits at G-1.
    assign win_end = (t == T_MAX);

    // Next time value: restart on a new window, count while a window is open, never wrap.
    always_comb begin
        t_next = t;
        if (load) begin
            t_next = '0;
        end else if (run && !win_end) begin
            t_next = t + 1'b1;
        end
    end

    // Time register.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            t <= '0;
        end else begin
            t <= t_next;
        end
    end

endmodule

// File: rtl/temporal_encoder.sv
// rtl/temporal_encoder.sv - temporal (spike-time) encoder; TEMPORAL_EDGE_MODE_EN selects edge coding
module temporal_encoder
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8
) (
    input  logic                     aclk,
    input  logic                     grst,
    temporal_encoder_if.slave        in_if,
    input  logic                     gamma_start,
    output logic                     spike,
    output logic                     busy
);

    localparam int VAL_WIDTH = $clog2(GAMMA_CYCLE_WIDTH) + 1;
    localparam int TW        = VAL_WIDTH - 1;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] PULSE = ST_PULSE;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic                 pending_valid;
    logic [VAL_WIDTH-1:0] pending_value;
    logic [VAL_WIDTH-1:0] active_value;
    logic [TW-1:0]        t_next;
    logic                 win_end;
    logic                 transfer;
    logic                 pulse_done;

    // The slot is free either when empty or when it is being drained into the new window.
    assign in_if.in_ready = !pending_valid || gamma_start;
    assign transfer       = in_if.in_valid && in_if.in_ready;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH)
    ) u_gamma_counter (
        .aclk    (aclk),
        .grst    (grst),
        .load    (gamma_start),
        .run     (state != IDLE),
        .t_next  (t_next),
        .win_end (win_end)
    );

`ifdef TEMPORAL_EDGE_MODE_EN
    // Edge coding: once risen the spike holds until the window closes.
    assign pulse_done = 1'b0;
`else
    localparam logic [31:0] PW_L = PULSE_WIDTH;
    // Pulse coding: the pulse ends once t reaches v + PW.
    assign pulse_done = (32'(t_next) >= 32'(active_value) + PW_L);
`endif

    // Next-state logic; gamma_start overrides everything and opens a fresh window.
    always_comb begin
        state_next = state;
        if (gamma_start) begin
            if (!pending_valid || is_infinite(32'(pending_value), GAMMA_CYCLE_WIDTH)) begin
                state_next = DONE;
            end else if (pending_value == '0) begin
                state_next = PULSE;
            end else begin
                state_next = WAIT;
            end
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                WAIT: begin
                    if (win_end) begin
                        state_next = IDLE;
                    end else if ({1'b0, t_next} == active_value) begin
                        state_next = PULSE;
                    end
                end
                PULSE: begin
                    if (win_end) begin
                        state_next = IDLE;
                    end else if (pulse_done) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (win_end) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and registered outputs follow the state being entered.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state <= IDLE;
            spike <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            spike <= (state_next == PULSE);
            busy  <= (state_next != IDLE);
        end
    end

    // Pending slot and active value; a value arriving on the gamma_start edge waits for the next window.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            pending_valid <= 1'b0;
            pending_value <= '0;
            active_value  <= '0;
        end else if (gamma_start) begin
            if (pending_valid) begin
                active_value <= pending_value;
            end
            pending_valid <= transfer;
            if (transfer) begin
                pending_value <= in_if.in_value;
            end
        end else if (transfer) begin
            pending_valid <= 1'b1;
            pending_value <= in_if.in_value;
        end
    end

endmodule

// File: tb/tb_temporal_encoder.sv
// tb/tb_temporal_encoder.sv - self-checking bench for temporal_encoder against a window-arithmetic model
module tb_temporal_encoder;

    localparam int G  = 16;
    localparam int PW = 8;
`ifdef TEMPORAL_EDGE_MODE_EN
    localparam int PW_EFF = G;
`else
    localparam int PW_EFF = PW;
`endif

    logic aclk = 1'b0;
    logic grst;
    logic gamma_start;
    logic spike;
    logic busy;

    temporal_encoder_if #(.VAL_WIDTH(5)) in_if ();

    temporal_encoder #(
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (PW)
    ) dut (
        .aclk        (aclk),
        .grst        (grst),
        .in_if       (in_if),
        .gamma_start (gamma_start),
        .spike       (spike),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int spike_cnt;
    int busy_cnt;

    // Reference model: one pending slot plus the parameters of the current window.
    bit pend_valid;
    int pend_v;
    bit win_open;
    bit win_has;
    int win_v;
    int win_start;
    int last_edge;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (time %0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_clear();
        pend_valid = 1'b0;
        pend_v     = 0;
        win_open   = 1'b0;
        win_has    = 1'b0;
        win_v      = 0;
        win_start  = 0;
    endtask

    // One clock: check outputs, drive inputs, check in_ready, then advance the model at the edge.
    task automatic step(input logic vv, input logic [4:0] vd, input logic gs);
        int k;
        bit exp_busy;
        bit exp_spike;
        bit exp_ready;
        bit xfer;
        @(negedge aclk);
        k         = last_edge - win_start;
        exp_busy  = win_open && (k <= G - 1);
        exp_spike = exp_busy && win_has && (win_v < G) && (k >= win_v) && (k < win_v + PW_EFF);
        check("spike", int'(spike), int'(exp_spike));
        check("busy", int'(busy), int'(exp_busy));
        if (spike) spike_cnt++;
        if (busy) busy_cnt++;
        in_if.in_valid = vv;
        in_if.in_value = vd;
        gamma_start    = gs;
        #1;
        exp_ready = !pend_valid || gs;
        check("in_ready", int'(in_if.in_ready), int'(exp_ready));
        @(posedge aclk);
        last_edge++;
        xfer = vv && exp_ready;
        if (gs) begin
            win_open   = 1'b1;
            win_start  = last_edge;
            win_has    = pend_valid;
            win_v      = pend_v;
            pend_valid = xfer;
            if (xfer) pend_v = int'(vd);
        end else if (xfer) begin
            pend_valid = 1'b1;
            pend_v     = int'(vd);
        end
    endtask

    // Asynchronous reset a little after an active edge; outputs must drop before the next edge.
    task automatic do_reset();
        in_if.in_valid = 1'b0;
        gamma_start    = 1'b0;
        #2;
        grst = 1'b1;
        #1;
        check("rst_spike", int'(spike), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(in_if.in_ready), 1);
        model_clear();
        @(negedge aclk);
        grst = 1'b0;
    endtask

    // Open one window (optionally loading v first) and count spike/busy cycles across it.
    task automatic run_window(input bit load, input int v);
        int exp;
        if (load) step(1'b1, 5'(v), 1'b0);
        step(1'b0, 5'd0, 1'b1);
        spike_cnt = 0;
        busy_cnt  = 0;
        repeat (G + 2) step(1'b0, 5'd0, 1'b0);
        if (!load || v >= G) exp = 0;
        else exp = ((G - v) < PW_EFF) ? (G - v) : PW_EFF;
        check($sformatf("win_spikes_v%0d", v), spike_cnt, exp);
        check($sformatf("win_busy_v%0d", v), busy_cnt, G);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        grst           = 1'b1;
        gamma_start    = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_value = '0;
        model_clear();
        last_edge = 0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_spike", int'(spike), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(in_if.in_ready), 1);
        @(negedge aclk);
        grst = 1'b0;

        // Basic windows, clipping, v=0, infinity and empty slot.
        run_window(1'b1, 3);
        run_window(1'b1, 12);
        run_window(1'b1, 0);
        run_window(1'b1, 16);
        run_window(1'b0, 0);

        // Abort an open window at t=5 with v=1 pending.
        step(1'b1, 5'd3, 1'b0);
        step(1'b0, 5'd0, 1'b1);
        step(1'b1, 5'd1, 1'b0);
        repeat (4) step(1'b0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 1'b1);
        spike_cnt = 0;
        repeat (G + 2) step(1'b0, 5'd0, 1'b0);
        check("abort_spikes", spike_cnt, PW_EFF < G - 1 ? PW_EFF : G - 1);

        // Back-to-back offers: second is held off until the gamma_start edge.
        step(1'b1, 5'd5, 1'b0);
        step(1'b1, 5'd7, 1'b0);
        step(1'b1, 5'd7, 1'b0);
        step(1'b1, 5'd7, 1'b1);
        repeat (G + 2) step(1'b0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 1'b1);
        spike_cnt = 0;
        repeat (G + 2) step(1'b0, 5'd0, 1'b0);
        check("second_val_spikes", spike_cnt, PW_EFF < G - 7 ? PW_EFF : G - 7);

        // Reset mid-pulse, then a window with nothing loaded.
        step(1'b1, 5'd3, 1'b0);
        step(1'b0, 5'd0, 1'b1);
        repeat (6) step(1'b0, 5'd0, 1'b0);
        check("pre_rst_spike", int'(spike), 1);
        do_reset();
        step(1'b0, 5'd0, 1'b1);
        spike_cnt = 0;
        busy_cnt  = 0;
        repeat (G + 2) step(1'b0, 5'd0, 1'b0);
        check("post_rst_spikes", spike_cnt, 0);
        check("post_rst_busy", busy_cnt, G);

        // Randomized traffic including mid-window restarts and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 20)),
                     $urandom_range(0, 13) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
